pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Next-generation control unit for the 5-stage MIPS-like pipeline.
- Decodes the ID-stage instruction and carries the EX/MEM/WB control bits through internal ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and jump-register hazards, generates forwarding selects, and drives PC select, stall and flush signals.
- Width-parametrised; forwarding can be enabled or replaced by full stalling.

Parameters:
- OPC_W, 6, opcode field width
- FUNC_W, 6, function field width
- REG_AW, 5, register address width
- LINK_REG, 31, destination register written by jal
- FORWARDING, 1, 1 = forward from MEM/WB; 0 = stall on every RAW hazard, fwd_a and fwd_b held at 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_opc  in  OPC_W  opcode of the instruction in ID
- id_funct  in  FUNC_W  function field in ID
- id_rs, id_rt, id_rd  in  REG_AW each  register fields in ID
- ex_zero  in  1  ALU zero flag of the instruction in EX
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID on next edge
- pc_sel  out  2  next-PC select: 0 = pc+4, 1 = branch target, 2 = jump target, 3 = rs value
- ex_alu_src, ex_alu_op[2:0], ex_reg_dst  out  EX-stage controls
- ex_link  out  1  EX is jal; the EX result is pc+4
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB
- mem_read, mem_write  out  1 each  MEM-stage controls
- wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls
- wb_dst  out  REG_AW  WB destination register

Behaviour:

Decode (combinational, ID):
- Opcodes: R = 0, addi = 1, slti = 2, lw = 3, sw = 4, beq = 5, j = 6, jr = 7, jal = 8. Any other opcode decodes as a NOP with all controls 0.
- R-type functions are one-hot: ADD = 1, SUB = 2, AND = 4, OR = 8, SLT = 16. alu_op values are 000, 001, 010, 011, 111 respectively. An unknown function gives alu_op 000 with reg_write = 0.
- addi: alu_op 000. slti: alu_op 111. lw and sw: alu_op 000, alu_src = 1. beq: alu_op 001, alu_src = 0.
- Destination register: rd when reg_dst = 1, rt otherwise, LINK_REG for jal.
- Any destination equal to 0 forces reg_write to 0.

Control pipeline:
- On every clk edge, ID controls move to ID/EX, ID/EX to EX/MEM, and EX/MEM to MEM/WB.
- ID/EX also stores id_rs, id_rt, the destination, and a branch flag.
- A bubble loads all-zero controls into ID/EX.

Hazards (combinational from current state):
- Load-use: EX mem_read and ex_dst ∈ {id_rs if used, id_rt if used} → stall.
  - rs is used by R, addi, slti, lw, sw, beq, jr. rt is used by R, sw, beq.
- jr: any EX or MEM reg_write with dst == id_rs → stall.
- FORWARDING = 0: a source used in ID that matches the EX or MEM destination with reg_write → stall. The register file is write-before-read, so WB needs no check.
- Stall: pc_write = 0, ifid_write = 0, bubble into ID/EX.

Control flow:
- Taken branch: EX branch flag and ex_zero → pc_sel = 1, ifid_flush = 1, bubble into ID/EX. This overrides any stall in the same cycle; pc_write = 1.
- Jumps: j and jal → pc_sel = 2; jr (when not stalled) → pc_sel = 3. Each also sets ifid_flush = 1. The jump itself proceeds down the pipe; jal writes the link register.

Forwarding (per EX source, FORWARDING = 1):
- 10 when the MEM stage has reg_write and its dst matches the source.
- Otherwise 01 when WB has reg_write and its dst matches the source.
- Otherwise 00. MEM has priority over WB.

Reset:
- All control registers clear asynchronously at any time, so in-flight instructions become bubbles.
- While rst is high: pc_write = 1, ifid_write = 1, ifid_flush = 0, pc_sel = 0, fwd = 00, and every stage control output = 0.

Test Plan:
- rst mid-stream with lw in EX and beq in MEM → all stage controls read 0 in the same cycle; pc_write = 1 and pc_sel = 0 after release.
- lw r2 followed by add r3,r2,r4 → one stall cycle (pc_write = 0, ID/EX bubble). Next cycle the add is in EX with fwd_a = 01 (load data from WB), alu_op = 000.
- add r5,r1,r1; sub r6,r5,r5 → when the sub is in EX, fwd_a = fwd_b = 10, alu_op = 001, no stall. Repeat with FORWARDING = 0 → two stall cycles, fwd = 00.
- beq with ex_zero = 1 while a load-use stall is pending in ID → pc_sel = 1, ifid_flush = 1, pc_write = 1, ID/EX bubble. With ex_zero = 0 → pc_sel = 0 and the stall applies.
- jal → pc_sel = 2, ifid_flush = 1. Three cycles later wb_reg_write = 1 and wb_dst = 31.
- jr r7 immediately after addi r7 → stall until the addi leaves MEM (2 cycles), then pc_sel = 3. Also check that opcode 9 yields all controls 0 and that add rd = 0 yields wb_reg_write = 0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Control unit for a 5-stage MIPS-like pipeline: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control registers, hazard detection, forwarding selects and next-PC steering.
module pipe_ctrl_unit #(
  parameter int OPC_W      = 6,
  parameter int FUNC_W     = 6,
  parameter int REG_AW     = 5,
  parameter int LINK_REG   = 31,
  parameter int FORWARDING = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  id_opc,
  input  logic [FUNC_W-1:0] id_funct,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        pc_sel,
  output logic              ex_alu_src,
  output logic [2:0]        ex_alu_op,
  output logic              ex_reg_dst,
  output logic              ex_link,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dst
);

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       link;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam logic [OPC_W-1:0]  OP_R    = OPC_W'(0);
  localparam logic [OPC_W-1:0]  OP_ADDI = OPC_W'(1);
  localparam logic [OPC_W-1:0]  OP_SLTI = OPC_W'(2);
  localparam logic [OPC_W-1:0]  OP_LW   = OPC_W'(3);
  localparam logic [OPC_W-1:0]  OP_SW   = OPC_W'(4);
  localparam logic [OPC_W-1:0]  OP_BEQ  = OPC_W'(5);
  localparam logic [OPC_W-1:0]  OP_J    = OPC_W'(6);
  localparam logic [OPC_W-1:0]  OP_JR   = OPC_W'(7);
  localparam logic [OPC_W-1:0]  OP_JAL  = OPC_W'(8);
  localparam logic [FUNC_W-1:0] F_ADD   = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] F_SUB   = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] F_AND   = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] F_OR    = FUNC_W'(8);
  localparam logic [FUNC_W-1:0] F_SLT   = FUNC_W'(16);
  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(0);

  ctrl_t             id_ctrl_s;
  logic [REG_AW-1:0] id_dst_s;
  logic              rs_used_s, rt_used_s, is_jmp_s, is_jr_s;

  ctrl_t             idex_ctrl_r;
  logic [REG_AW-1:0] idex_rs_r, idex_rt_r, idex_dst_r;
  logic              exmem_mem_read_r, exmem_mem_write_r, exmem_reg_write_r, exmem_mem_to_reg_r;
  logic [REG_AW-1:0] exmem_dst_r;
  logic              memwb_reg_write_r, memwb_mem_to_reg_r;
  logic [REG_AW-1:0] memwb_dst_r;

  logic load_use_s, jr_haz_s, raw_haz_s, stall_s, taken_s, bubble_s;
  logic ex_rs_s, ex_rt_s, mem_rs_s, mem_rt_s;

  // ID decode: controls, destination register and source-usage flags
  always_comb begin
    id_ctrl_s = '0;
    id_dst_s  = id_rt;
    rs_used_s = 1'b0;
    rt_used_s = 1'b0;
    is_jmp_s  = 1'b0;
    is_jr_s   = 1'b0;
    case (id_opc)
      OP_R: begin
        rs_used_s           = 1'b1;
        rt_used_s           = 1'b1;
        id_ctrl_s.reg_dst   = 1'b1;
        id_ctrl_s.reg_write = 1'b1;
        id_dst_s            = id_rd;
        case (id_funct)
          F_ADD:   id_ctrl_s.alu_op = 3'b000;
          F_SUB:   id_ctrl_s.alu_op = 3'b001;
          F_AND:   id_ctrl_s.alu_op = 3'b010;
          F_OR:    id_ctrl_s.alu_op = 3'b011;
          F_SLT:   id_ctrl_s.alu_op = 3'b111;
          default: begin
            id_ctrl_s.alu_op    = 3'b000;
            id_ctrl_s.reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        rs_used_s           = 1'b1;
        id_ctrl_s.alu_src   = 1'b1;
        id_ctrl_s.reg_write = 1'b1;
      end
      OP_SLTI: begin
        rs_used_s           = 1'b1;
        id_ctrl_s.alu_src   = 1'b1;
        id_ctrl_s.alu_op    = 3'b111;
        id_ctrl_s.reg_write = 1'b1;
      end
      OP_LW: begin
        rs_used_s            = 1'b1;
        id_ctrl_s.alu_src    = 1'b1;
        id_ctrl_s.mem_read   = 1'b1;
        id_ctrl_s.mem_to_reg = 1'b1;
        id_ctrl_s.reg_write  = 1'b1;
      end
      OP_SW: begin
        rs_used_s           = 1'b1;
        rt_used_s           = 1'b1;
        id_ctrl_s.alu_src   = 1'b1;
        id_ctrl_s.mem_write = 1'b1;
      end
      OP_BEQ: begin
        rs_used_s        = 1'b1;
        rt_used_s        = 1'b1;
        id_ctrl_s.alu_op = 3'b001;
        id_ctrl_s.branch = 1'b1;
      end
      OP_J:  is_jmp_s = 1'b1;
      OP_JR: begin
        rs_used_s = 1'b1;
        is_jr_s   = 1'b1;
      end
      OP_JAL: begin
        is_jmp_s            = 1'b1;
        id_ctrl_s.link      = 1'b1;
        id_ctrl_s.reg_write = 1'b1;
        id_dst_s            = REG_AW'(LINK_REG);
      end
      default: id_ctrl_s = '0;
    endcase
    id_ctrl_s.reg_write = id_ctrl_s.reg_write & (id_dst_s != ZERO_REG);
  end

  // Hazard detection against the instructions currently in EX and MEM
  always_comb begin
    ex_rs_s    = idex_ctrl_r.reg_write && (idex_dst_r == id_rs);
    ex_rt_s    = idex_ctrl_r.reg_write && (idex_dst_r == id_rt);
    mem_rs_s   = exmem_reg_write_r && (exmem_dst_r == id_rs);
    mem_rt_s   = exmem_reg_write_r && (exmem_dst_r == id_rt);
    load_use_s = idex_ctrl_r.mem_read &&
                 ((rs_used_s && (idex_dst_r == id_rs)) || (rt_used_s && (idex_dst_r == id_rt)));
    jr_haz_s   = is_jr_s && (ex_rs_s || mem_rs_s);
    if (FORWARDING == 0) begin
      raw_haz_s = (rs_used_s && (ex_rs_s || mem_rs_s)) || (rt_used_s && (ex_rt_s || mem_rt_s));
    end else begin
      raw_haz_s = 1'b0;
    end
    stall_s = load_use_s || jr_haz_s || raw_haz_s;
    taken_s = idex_ctrl_r.branch && ex_zero;
  end

  // Next-PC steering; a taken branch in EX outranks any stall or jump in ID
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pc_sel     = 2'b00;
    bubble_s   = 1'b0;
    if (rst) begin
      pc_sel = 2'b00;
    end else if (taken_s) begin
      pc_sel     = 2'b01;
      ifid_flush = 1'b1;
      bubble_s   = 1'b1;
    end else if (stall_s) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble_s   = 1'b1;
    end else if (is_jmp_s) begin
      pc_sel     = 2'b10;
      ifid_flush = 1'b1;
    end else if (is_jr_s) begin
      pc_sel     = 2'b11;
      ifid_flush = 1'b1;
    end else begin
      pc_sel = 2'b00;
    end
  end

  // Operand forwarding for EX; the younger MEM result wins over WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if ((FORWARDING != 0) && !rst) begin
      if (exmem_reg_write_r && (exmem_dst_r == idex_rs_r)) begin
        fwd_a = 2'b10;
      end else if (memwb_reg_write_r && (memwb_dst_r == idex_rs_r)) begin
        fwd_a = 2'b01;
      end else begin
        fwd_a = 2'b00;
      end
      if (exmem_reg_write_r && (exmem_dst_r == idex_rt_r)) begin
        fwd_b = 2'b10;
      end else if (memwb_reg_write_r && (memwb_dst_r == idex_rt_r)) begin
        fwd_b = 2'b01;
      end else begin
        fwd_b = 2'b00;
      end
    end else begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

  // ID/EX control register; a bubble clears controls and operand tags alike
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ctrl_r <= '0;
      idex_rs_r   <= ZERO_REG;
      idex_rt_r   <= ZERO_REG;
      idex_dst_r  <= ZERO_REG;
    end else if (bubble_s) begin
      idex_ctrl_r <= '0;
      idex_rs_r   <= ZERO_REG;
      idex_rt_r   <= ZERO_REG;
      idex_dst_r  <= ZERO_REG;
    end else begin
      idex_ctrl_r <= id_ctrl_s;
      idex_rs_r   <= id_rs;
      idex_rt_r   <= id_rt;
      idex_dst_r  <= id_dst_s;
    end
  end

  // EX/MEM and MEM/WB control registers advance every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_mem_read_r   <= 1'b0;
      exmem_mem_write_r  <= 1'b0;
      exmem_reg_write_r  <= 1'b0;
      exmem_mem_to_reg_r <= 1'b0;
      exmem_dst_r        <= ZERO_REG;
      memwb_reg_write_r  <= 1'b0;
      memwb_mem_to_reg_r <= 1'b0;
      memwb_dst_r        <= ZERO_REG;
    end else begin
      exmem_mem_read_r   <= idex_ctrl_r.mem_read;
      exmem_mem_write_r  <= idex_ctrl_r.mem_write;
      exmem_reg_write_r  <= idex_ctrl_r.reg_write;
      exmem_mem_to_reg_r <= idex_ctrl_r.mem_to_reg;
      exmem_dst_r        <= idex_dst_r;
      memwb_reg_write_r  <= exmem_reg_write_r;
      memwb_mem_to_reg_r <= exmem_mem_to_reg_r;
      memwb_dst_r        <= exmem_dst_r;
    end
  end

  assign ex_alu_src    = idex_ctrl_r.alu_src;
  assign ex_alu_op     = idex_ctrl_r.alu_op;
  assign ex_reg_dst    = idex_ctrl_r.reg_dst;
  assign ex_link       = idex_ctrl_r.link;
  assign mem_read      = exmem_mem_read_r;
  assign mem_write     = exmem_mem_write_r;
  assign wb_reg_write  = memwb_reg_write_r;
  assign wb_mem_to_reg = memwb_mem_to_reg_r;
  assign wb_dst        = memwb_dst_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: two instances (forwarding on / full stalling),
// expectations queued with their due cycle and compared when that cycle is sampled.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] id_opc, id_funct, s_id_opc, s_id_funct;
  logic [4:0] id_rs, id_rt, id_rd, s_id_rs, s_id_rt, s_id_rd;
  logic       ex_zero, s_ex_zero;

  logic       pc_write, ifid_write, ifid_flush, ex_alu_src, ex_reg_dst, ex_link;
  logic       mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
  logic [1:0] pc_sel, fwd_a, fwd_b;
  logic [2:0] ex_alu_op;
  logic [4:0] wb_dst;
  logic       s_pc_write, s_ifid_write, s_ifid_flush, s_ex_alu_src, s_ex_reg_dst, s_ex_link;
  logic       s_mem_read, s_mem_write, s_wb_reg_write, s_wb_mem_to_reg;
  logic [1:0] s_pc_sel, s_fwd_a, s_fwd_b;
  logic [2:0] s_ex_alu_op;
  logic [4:0] s_wb_dst;

  pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .id_opc(id_opc), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .pc_sel(pc_sel), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_reg_dst(ex_reg_dst), .ex_link(ex_link), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
  );

  pipe_ctrl_unit #(.FORWARDING(0)) dut_stall (
    .clk(clk), .rst(rst), .id_opc(s_id_opc), .id_funct(s_id_funct), .id_rs(s_id_rs),
    .id_rt(s_id_rt), .id_rd(s_id_rd), .ex_zero(s_ex_zero), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .pc_sel(s_pc_sel),
    .ex_alu_src(s_ex_alu_src), .ex_alu_op(s_ex_alu_op), .ex_reg_dst(s_ex_reg_dst),
    .ex_link(s_ex_link), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .wb_reg_write(s_wb_reg_write), .wb_mem_to_reg(s_wb_mem_to_reg),
    .wb_dst(s_wb_dst)
  );

  always #5 clk = ~clk;

  localparam int PCW = 0, IFW = 1, FLUSH = 2, PCSEL = 3, SRC = 4, ALUOP = 5, RDST = 6;
  localparam int LINK = 7, FA = 8, FB = 9, MRD = 10, MWR = 11, WBW = 12, WBM = 13, WBD = 14;
  localparam int S = 20;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // table: opc, funct, rs, rt, rd, alu_op, alu_src, reg_dst, mem_write, wb_reg_write, wb_dst (-1 = skip)
  int t_opc [10] = '{0, 0, 0, 0, 0, 0, 2, 4, 9, 0};
  int t_fn  [10] = '{1, 2, 4, 8, 16, 3, 0, 0, 1, 1};
  int t_rs  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int t_rt  [10] = '{1, 2, 1, 2, 1, 2, 9, 2, 3, 1};
  int t_rd  [10] = '{10, 11, 12, 13, 14, 15, 0, 0, 4, 0};
  int t_op  [10] = '{0, 1, 2, 3, 7, 0, 7, 0, 0, 0};
  int t_src [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  int t_rdst[10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
  int t_mw  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int t_w   [10] = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 0};
  int t_dst [10] = '{10, 11, 12, 13, 14, -1, 9, -1, -1, -1};

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      PCW:       return 32'(pc_write);
      IFW:       return 32'(ifid_write);
      FLUSH:     return 32'(ifid_flush);
      PCSEL:     return 32'(pc_sel);
      SRC:       return 32'(ex_alu_src);
      ALUOP:     return 32'(ex_alu_op);
      RDST:      return 32'(ex_reg_dst);
      LINK:      return 32'(ex_link);
      FA:        return 32'(fwd_a);
      FB:        return 32'(fwd_b);
      MRD:       return 32'(mem_read);
      MWR:       return 32'(mem_write);
      WBW:       return 32'(wb_reg_write);
      WBM:       return 32'(wb_mem_to_reg);
      WBD:       return 32'(wb_dst);
      S + PCW:   return 32'(s_pc_write);
      S + IFW:   return 32'(s_ifid_write);
      S + FLUSH: return 32'(s_ifid_flush);
      S + PCSEL: return 32'(s_pc_sel);
      S + SRC:   return 32'(s_ex_alu_src);
      S + ALUOP: return 32'(s_ex_alu_op);
      S + RDST:  return 32'(s_ex_reg_dst);
      S + LINK:  return 32'(s_ex_link);
      S + FA:    return 32'(s_fwd_a);
      S + FB:    return 32'(s_fwd_b);
      S + MRD:   return 32'(s_mem_read);
      S + MWR:   return 32'(s_mem_write);
      S + WBW:   return 32'(s_wb_reg_write);
      S + WBM:   return 32'(s_wb_mem_to_reg);
      S + WBD:   return 32'(s_wb_dst);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_at(input string tag, input int sel, input int val, input int lat);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 32'(val);
    e.due = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic check_due();
    exp_t        keep[$];
    logic [31:0] obs;
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cyc) begin
        obs = observe(exp_q[i].sel);
        checks++;
        assert (obs === exp_q[i].val) else begin
          errors++;
          $error("FAIL %s (cycle %0d): observed %0h expected %0h", exp_q[i].tag, cyc, obs, exp_q[i].val);
        end
      end else begin
        keep.push_back(exp_q[i]);
      end
    end
    exp_q = keep;
  endtask

  task automatic tick();
    @(negedge clk);
    check_due();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ins(input int opc, input int fn, input int rs, input int rt, input int rd);
    id_opc   = 6'(opc);
    id_funct = 6'(fn);
    id_rs    = 5'(rs);
    id_rt    = 5'(rt);
    id_rd    = 5'(rd);
  endtask

  task automatic ins_s(input int opc, input int fn, input int rs, input int rt, input int rd);
    s_id_opc   = 6'(opc);
    s_id_funct = 6'(fn);
    s_id_rs    = 5'(rs);
    s_id_rt    = 5'(rt);
    s_id_rd    = 5'(rd);
  endtask

  initial begin
    rst = 1'b1;
    ex_zero = 1'b0;
    s_ex_zero = 1'b0;
    ins_s(63, 0, 0, 0, 0);

    // reset held with a j in ID: steering must stay neutral
    ins(6, 0, 0, 0, 0);
    expect_at("rst_pcw", PCW, 1, 0);
    expect_at("rst_ifw", IFW, 1, 0);
    expect_at("rst_flush", FLUSH, 0, 0);
    expect_at("rst_pcsel", PCSEL, 0, 0);
    expect_at("rst_wbw", WBW, 0, 0);
    expect_at("rst_mrd", MRD, 0, 0);
    tick();
    rst = 1'b0;
    ins(63, 0, 0, 0, 0);
    expect_at("idle_pcw", PCW, 1, 0);
    tick();

    // lw r2 ; add r3,r2,r4 : one load-use stall, then WB forwarding
    ins(3, 0, 1, 2, 0);
    expect_at("lw_pcw", PCW, 1, 0);
    tick();
    ins(0, 1, 2, 4, 3);
    expect_at("lu_pcw", PCW, 0, 0);
    expect_at("lu_ifw", IFW, 0, 0);
    expect_at("lu_lw_src", SRC, 1, 0);
    expect_at("add_wbw", WBW, 1, 4);
    expect_at("add_wbd", WBD, 3, 4);
    tick();
    expect_at("lu_bubble_src", SRC, 0, 0);
    expect_at("lu_release_pcw", PCW, 1, 0);
    expect_at("lw_mrd", MRD, 1, 0);
    tick();
    ins(63, 0, 0, 0, 0);
    expect_at("lu_fwd_a", FA, 1, 0);
    expect_at("lu_fwd_b", FB, 0, 0);
    expect_at("lu_aluop", ALUOP, 0, 0);
    expect_at("lu_rdst", RDST, 1, 0);
    expect_at("lw_wbm", WBM, 1, 0);
    expect_at("lw_wbd", WBD, 2, 0);
    tick();
    tick();
    tick();

    // add r5,r1,r1 ; sub r6,r5,r5 on both instances
    ins(0, 1, 1, 1, 5);
    ins_s(0, 1, 1, 1, 5);
    tick();
    ins(0, 2, 5, 5, 6);
    ins_s(0, 2, 5, 5, 6);
    expect_at("fw_pcw", PCW, 1, 0);
    expect_at("st_pcw1", S + PCW, 0, 0);
    expect_at("sub_wbd", WBD, 6, 3);
    tick();
    ins(63, 0, 0, 0, 0);
    expect_at("fw_fwd_a", FA, 2, 0);
    expect_at("fw_fwd_b", FB, 2, 0);
    expect_at("fw_aluop", ALUOP, 1, 0);
    expect_at("st_pcw2", S + PCW, 0, 0);
    expect_at("st_fwd_a_stall", S + FA, 0, 0);
    tick();
    expect_at("st_release", S + PCW, 1, 0);
    tick();
    ins_s(63, 0, 0, 0, 0);
    expect_at("st_aluop", S + ALUOP, 1, 0);
    expect_at("st_fwd_a", S + FA, 0, 0);
    expect_at("st_fwd_b", S + FB, 0, 0);
    tick();
    tick();
    tick();

    // addi r7 ; beq (taken) ; jr r7 pending a stall : the branch wins
    ins(1, 0, 0, 7, 0);
    tick();
    ins(5, 0, 1, 2, 0);
    expect_at("beq_id_pcw", PCW, 1, 0);
    tick();
    ins(7, 0, 7, 0, 0);
    ex_zero = 1'b1;
    expect_at("tk_pcsel", PCSEL, 1, 0);
    expect_at("tk_flush", FLUSH, 1, 0);
    expect_at("tk_pcw", PCW, 1, 0);
    expect_at("tk_ifw", IFW, 1, 0);
    tick();
    ex_zero = 1'b0;
    ins(63, 0, 0, 0, 0);
    expect_at("tk_bubble_op", ALUOP, 0, 0);
    expect_at("tk_pcsel_after", PCSEL, 0, 0);
    tick();

    // same sequence, branch not taken : the jr stall applies
    ins(1, 0, 0, 7, 0);
    tick();
    ins(5, 0, 1, 2, 0);
    tick();
    ins(7, 0, 7, 0, 0);
    expect_at("nt_pcsel", PCSEL, 0, 0);
    expect_at("nt_pcw", PCW, 0, 0);
    expect_at("nt_flush", FLUSH, 0, 0);
    tick();
    expect_at("nt_jr_pcsel", PCSEL, 3, 0);
    expect_at("nt_jr_flush", FLUSH, 1, 0);
    expect_at("nt_bubble_op", ALUOP, 0, 0);
    tick();
    ins(63, 0, 0, 0, 0);
    tick();

    // addi r7 ; jr r7 : two stall cycles, then pc_sel = 3
    ins(1, 0, 0, 7, 0);
    tick();
    ins(7, 0, 7, 0, 0);
    expect_at("jr_st1_pcw", PCW, 0, 0);
    expect_at("jr_st1_pcsel", PCSEL, 0, 0);
    tick();
    expect_at("jr_st2_pcw", PCW, 0, 0);
    expect_at("jr_st2_pcsel", PCSEL, 0, 0);
    tick();
    expect_at("jr_go_pcsel", PCSEL, 3, 0);
    expect_at("jr_go_flush", FLUSH, 1, 0);
    expect_at("jr_go_pcw", PCW, 1, 0);
    tick();
    ins(63, 0, 0, 0, 0);
    tick();

    // jal : jump steering now, link write three cycles later
    ins(8, 0, 0, 0, 0);
    expect_at("jal_pcsel", PCSEL, 2, 0);
    expect_at("jal_flush", FLUSH, 1, 0);
    expect_at("jal_pcw", PCW, 1, 0);
    expect_at("jal_link", LINK, 1, 1);
    expect_at("jal_wbw", WBW, 1, 3);
    expect_at("jal_wbd", WBD, 31, 3);
    tick();
    ins(63, 0, 0, 0, 0);
    tick();
    tick();
    tick();

    // decode table streamed back to back
    for (int i = 0; i < 10; i++) begin
      ins(t_opc[i], t_fn[i], t_rs[i], t_rt[i], t_rd[i]);
      expect_at($sformatf("tbl%0d_aluop", i), ALUOP, t_op[i], 1);
      expect_at($sformatf("tbl%0d_src", i), SRC, t_src[i], 1);
      expect_at($sformatf("tbl%0d_rdst", i), RDST, t_rdst[i], 1);
      expect_at($sformatf("tbl%0d_link", i), LINK, 0, 1);
      expect_at($sformatf("tbl%0d_mrd", i), MRD, 0, 2);
      expect_at($sformatf("tbl%0d_mwr", i), MWR, t_mw[i], 2);
      expect_at($sformatf("tbl%0d_wbw", i), WBW, t_w[i], 3);
      if (t_dst[i] >= 0) begin
        expect_at($sformatf("tbl%0d_wbd", i), WBD, t_dst[i], 3);
      end else begin
        expect_at($sformatf("tbl%0d_wbm", i), WBM, 0, 3);
      end
      tick();
    end
    ins(63, 0, 0, 0, 0);
    tick();
    tick();
    tick();

    // reset mid-cycle with addi in WB, beq in MEM, lw in EX and a load-use in ID
    ins(1, 0, 0, 7, 0);
    tick();
    ins(5, 0, 1, 2, 0);
    tick();
    ins(3, 0, 1, 2, 0);
    tick();
    ins(0, 1, 2, 4, 3);
    expect_at("pre_rst_pcw", PCW, 0, 0);
    expect_at("pre_rst_src", SRC, 1, 0);
    expect_at("pre_rst_wbw", WBW, 1, 0);
    expect_at("pre_rst_wbd", WBD, 7, 0);
    @(negedge clk);
    check_due();
    #2;
    rst = 1'b1;
    #1;
    expect_at("mid_rst_src", SRC, 0, 0);
    expect_at("mid_rst_aluop", ALUOP, 0, 0);
    expect_at("mid_rst_mrd", MRD, 0, 0);
    expect_at("mid_rst_mwr", MWR, 0, 0);
    expect_at("mid_rst_wbw", WBW, 0, 0);
    expect_at("mid_rst_wbd", WBD, 0, 0);
    expect_at("mid_rst_pcw", PCW, 1, 0);
    expect_at("mid_rst_ifw", IFW, 1, 0);
    expect_at("mid_rst_pcsel", PCSEL, 0, 0);
    check_due();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    ins(63, 0, 0, 0, 0);
    expect_at("post_rst_pcw", PCW, 1, 0);
    expect_at("post_rst_pcsel", PCSEL, 0, 0);
    expect_at("post_rst_src", SRC, 0, 0);
    expect_at("post_rst_wbw", WBW, 0, 0);
    tick();
    tick();

    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation due at cycle %0d was never compared", exp_q[i].tag, exp_q[i].due);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
